serial_rx: RTL

SERIAL_RX -- requirements
Module: serial_rx

---
 rtl/serial_pkg.sv | 25 ++
 rtl/serial_sync.sv | 21 ++
 rtl/serial_rx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial receiver/transmitter pair: FSM state encoding
// and bit-period constant derivation (optional parity via SERIAL_RX_PARITY_EN).
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef SERIAL_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } serial_state_t;

    // Divider terminal count; one bit period spans baud_max()+1 clocks.
    function automatic int unsigned baud_max(input int unsigned freq, input int unsigned rate);
        return freq / rate;
    endfunction

    function automatic int unsigned half_bit(input int unsigned freq, input int unsigned rate);
        return baud_max(freq, rate) / 2;
    endfunction

endpackage

// File: rtl/serial_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset to idle-high.
module serial_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_rx.sv
// 8N1 UART receiver with mid-bit sampling and framing-error detection.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit and the parityError output.
module serial_rx #(
    parameter int INPUT_FREQUENCY = 25000000,
    parameter int BAUD_RATE       = 115200,
    parameter int BAUD_GEN_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
`ifdef SERIAL_RX_PARITY_EN
    output logic       parityError,
`endif
    output logic       frameError
);

    import serial_pkg::*;

    localparam logic [BAUD_GEN_WIDTH-1:0] BAUD_MAX =
        BAUD_GEN_WIDTH'(baud_max(INPUT_FREQUENCY, BAUD_RATE));
    localparam logic [BAUD_GEN_WIDTH-1:0] HALF_BIT =
        BAUD_GEN_WIDTH'(half_bit(INPUT_FREQUENCY, BAUD_RATE));

    serial_state_t             state;
    logic [BAUD_GEN_WIDTH-1:0] cnt;
    logic [2:0]                bit_idx;
    logic [7:0]                shift;
    logic                      rx_s;
`ifdef SERIAL_RX_PARITY_EN
    logic                      parity_bad;
`endif

    serial_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            data       <= '0;
            valid      <= 1'b0;
            frameError <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parityError <= 1'b0;
            parity_bad  <= 1'b0;
`endif
        end else begin
            valid      <= 1'b0;
            frameError <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parityError <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    // Re-check the line at mid start bit; a high line was only a glitch.
                    if (cnt == HALF_BIT) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BAUD_MAX) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BAUD_MAX) begin
                        cnt        <= '0;
                        parity_bad <= ^{shift, rx_s};
                        state      <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
                    if (cnt == BAUD_MAX) begin
                        cnt <= '0;
                        if (rx_s) begin
`ifdef SERIAL_RX_PARITY_EN
                            if (parity_bad) begin
                                parityError <= 1'b1;
                            end else begin
                                data  <= shift;
                                valid <= 1'b1;
                            end
`else
                            data  <= shift;
                            valid <= 1'b1;
`endif
                            state <= IDLE;
                        end else begin
                            frameError <= 1'b1;
                            state      <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
